// File: rtl/shift_sequencer.sv
// Command sequencer driving an 8-bit shift register's d/i/l/r inputs.
// Ports: c, rst, cmd_* handshake, q feedback, d/i/l/r drive, busy/done/err.
module shift_sequencer #(
  parameter int W     = 8,
  parameter int AMT_W = 3
) (
  input  logic             c,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [W-1:0]     cmd_data,
  input  logic [W-1:0]     q,
  output logic [W-1:0]     d,
  output logic             i,
  output logic             l,
  output logic             r,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_SHR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;
  localparam logic [2:0] OP_ROR  = 3'd5;
  localparam logic [2:0] OP_ASR  = 3'd6;
  localparam logic [2:0] OP_RSV  = 3'd7;

  localparam logic [AMT_W-1:0] CNT_ONE = 1;
  localparam logic [AMT_W-1:0] CNT_ZERO = '0;

  localparam logic [W-1:0] LSB_M = 1;
  localparam logic [W-1:0] MSB_M = LSB_M << (W - 1);

  state_t           state;
  state_t           nxt;
  logic [2:0]       op_r;
  logic [W-1:0]     data_r;
  logic [AMT_W-1:0] cnt;

  logic accept;
  logic is_sh;
  logic q_msb;
  logic q_lsb;

  assign accept = cmd_valid & cmd_ready;
  assign is_sh  = (cmd_op >= OP_SHL) && (cmd_op <= OP_ASR);

  // Masked reductions pick the fill bits off the live q.
  assign q_msb = |(q & MSB_M);
  assign q_lsb = |(q & LSB_M);

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_r   <= '0;
      data_r <= '0;
      cnt    <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        op_r   <= cmd_op;
        data_r <= cmd_data;
        cnt    <= cmd_amt;
      end else if (state == SHIFT && cnt != CNT_ONE) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_op == OP_LOAD)
            nxt = LOAD;
          else if (is_sh && cmd_amt != CNT_ZERO)
            nxt = SHIFT;
          else
            nxt = DONE;
        end
      end
      LOAD:  nxt = DONE;
      SHIFT: if (cnt == CNT_ONE) nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    d         = '0;
    i         = 1'b0;
    l         = 1'b0;
    r         = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      LOAD: begin
        l = 1'b1;
        r = 1'b1;
        d = data_r;
      end
      SHIFT: begin
        // (l,r)=01 moves toward MSB, 10 toward LSB.
        unique case (op_r)
          OP_SHL: r = 1'b1;
          OP_ROL: begin
            r = 1'b1;
            i = q_msb;
          end
          OP_SHR: l = 1'b1;
          OP_ROR: begin
            l = 1'b1;
            i = q_lsb;
          end
          OP_ASR: begin
            l = 1'b1;
            i = q_msb;
          end
          default: ;
        endcase
      end
      DONE: begin
        done = 1'b1;
        err  = (op_r == OP_RSV);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer driving a behavioural 8-bit register.
// q is fed back from the register model; expected values are hand-computed.
module tb_shift_sequencer;

  logic       c = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_amt;
  logic [7:0] cmd_data;
  logic [7:0] q = 8'h00;
  logic [7:0] d;
  logic       i;
  logic       l;
  logic       r;
  logic       busy;
  logic       done;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  int n_done = 0;
  int n_err = 0;

  shift_sequencer #(.W(8), .AMT_W(3)) dut (
    .c(c),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_amt(cmd_amt),
    .cmd_data(cmd_data),
    .q(q),
    .d(d),
    .i(i),
    .l(l),
    .r(r),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 c = ~c;

  // The downstream register: no reset.
  always @(posedge c) begin
    case ({l, r})
      2'b01: q <= {q[6:0], i};
      2'b10: q <= {i, q[7:1]};
      2'b11: q <= d;
      default: ;
    endcase
  end

  always @(posedge c) begin
    if (cmd_valid && cmd_ready) n_acc++;
    if (done) n_done++;
    if (done && err) n_err++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [2:0] op,
                     input logic [2:0] amt,
                     input logic [7:0] data,
                     output int lat);
    int w;
    w = 0;
    @(negedge c);
    while (!cmd_ready && w < 20) begin
      @(negedge c);
      w++;
    end
    chk("rdy_wait", {31'd0, cmd_ready}, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_amt   = amt;
    cmd_data  = data;
    @(negedge c);
    cmd_valid = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge c);
      lat++;
    end
    chk("done_wait", {31'd0, done}, 1);
  endtask

  initial begin
    int lat;
    int acc0;
    int dn0;
    int er0;
    int w;
    logic [2:0] qop  [3];
    logic [2:0] qamt [3];
    logic [7:0] qdat [3];

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_amt   = '0;
    cmd_data  = '0;
    repeat (3) @(negedge c);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_lr", {30'd0, l, r}, 0);
    chk("rst_d", {24'd0, d}, 0);
    chk("rst_i", {31'd0, i}, 0);
    rst = 1'b0;
    #1;
    chk("rst_rdy", {31'd0, cmd_ready}, 1);

    // 1: LOAD 0xA5, step by step
    @(negedge c);
    cmd_valid = 1'b1;
    cmd_op    = 3'd1;
    cmd_data  = 8'hA5;
    @(negedge c);
    cmd_valid = 1'b0;
    chk("t1_rdy", {31'd0, cmd_ready}, 0);
    chk("t1_busy", {31'd0, busy}, 1);
    chk("t1_lr", {30'd0, l, r}, 3);
    chk("t1_d", {24'd0, d}, 32'hA5);
    @(negedge c);
    chk("t1_q", {24'd0, q}, 32'hA5);
    chk("t1_done", {31'd0, done}, 1);
    chk("t1_err", {31'd0, err}, 0);
    @(negedge c);
    chk("t1_done1", {31'd0, done}, 0);
    chk("t1_idle", {30'd0, busy, cmd_ready}, 1);

    // 2: rotates
    run(3'd1, 3'd0, 8'h81, lat);
    chk("t2_ld", {24'd0, q}, 32'h81);
    chk("t2_ldlat", lat, 1);
    run(3'd4, 3'd3, 8'h00, lat);
    chk("t2_rol", {24'd0, q}, 32'h0C);
    chk("t2_rollat", lat, 3);
    run(3'd5, 3'd7, 8'h00, lat);
    chk("t2_ror", {24'd0, q}, 32'h18);
    chk("t2_rorlat", lat, 7);

    // 3: ASR, SHL full, SHR zero
    run(3'd1, 3'd0, 8'h90, lat);
    run(3'd6, 3'd2, 8'h00, lat);
    chk("t3_asr", {24'd0, q}, 32'hE4);
    run(3'd2, 3'd7, 8'h00, lat);
    chk("t3_shl", {24'd0, q}, 32'h00);
    run(3'd3, 3'd0, 8'h00, lat);
    chk("t3_z_lat", lat, 0);
    chk("t3_z_lr", {30'd0, l, r}, 0);
    chk("t3_z_q", {24'd0, q}, 32'h00);

    // 4: queued commands with valid held high
    @(negedge c);
    acc0 = n_acc;
    dn0  = n_done;
    er0  = n_err;
    qop[0] = 3'd1; qamt[0] = 3'd0; qdat[0] = 8'h3C;
    qop[1] = 3'd5; qamt[1] = 3'd1; qdat[1] = 8'h00;
    qop[2] = 3'd7; qamt[2] = 3'd0; qdat[2] = 8'h55;
    for (int k = 0; k < 3; k++) begin
      cmd_op    = qop[k];
      cmd_amt   = qamt[k];
      cmd_data  = qdat[k];
      cmd_valid = 1'b1;
      w = 0;
      while (!cmd_ready && w < 20) begin
        @(negedge c);
        w++;
      end
      chk("t4_rdy", {31'd0, cmd_ready}, 1);
      @(posedge c);
      #1;
    end
    cmd_valid = 1'b0;
    while (!done && w < 40) begin
      @(negedge c);
      w++;
    end
    chk("t4_errpulse", {30'd0, done, err}, 3);
    chk("t4_hold", {24'd0, q}, 32'h1E);
    repeat (4) @(negedge c);
    chk("t4_acc", n_acc - acc0, 3);
    chk("t4_done", n_done - dn0, 3);
    chk("t4_err", n_err - er0, 1);
    chk("t4_q", {24'd0, q}, 32'h1E);
    chk("t4_busy", {31'd0, busy}, 0);

    // 5: reset in the middle of SHL 6
    run(3'd1, 3'd0, 8'h01, lat);
    @(negedge c);
    cmd_valid = 1'b1;
    cmd_op    = 3'd2;
    cmd_amt   = 3'd6;
    @(posedge c);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge c);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_lr", {30'd0, l, r}, 0);
    chk("t5_i", {31'd0, i}, 0);
    chk("t5_d", {24'd0, d}, 0);
    chk("t5_de", {30'd0, done, err}, 0);
    chk("t5_busy", {31'd0, busy}, 0);
    @(negedge c);
    @(negedge c);
    chk("t5_q", {24'd0, q}, 32'h08);
    rst = 1'b0;
    run(3'd1, 3'd0, 8'hFF, lat);
    chk("t5_ld", {24'd0, q}, 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
